// File: rtl/etapa_busqueda.sv
`default_nettype none
// ============================================================================
//  Module      : etapa_busqueda
//  Description : Instruction-fetch stage and IF/ID pipeline register. Drives
//                the PC into a synchronous-read instruction memory, registers
//                the returned word and handles stall (one-entry hold buffer),
//                jump redirect, start and halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module etapa_busqueda #(
    parameter int              INSTR_W  = 16,
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [PC_W-1:0]    jump_addr,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic [3:0]         opcode_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      r_fetch_pc;   // address of the word on imem_data now
    logic                 r_fetch_vld;  // imem_data carries a real word now
    logic [INSTR_W-1:0]   r_hold_buf;   // word parked while stalled
    logic                 r_hold_vld;
    logic [INSTR_W-1:0]   r_instr;
    logic [PC_W-1:0]      r_pc_out;
    logic                 r_valid;

    logic                 w_run;
    logic [INSTR_W-1:0]   w_fetch_word;

    assign w_run        = (r_state == ST_RUN);
    // A parked word takes precedence: memory output is stale after a stall.
    assign w_fetch_word = r_hold_vld ? r_hold_buf : imem_data;

    assign imem_addr  = r_pc;
    assign imem_rd    = w_run & ~stall;
    assign busy       = w_run;
    assign instr_out  = r_instr;
    assign opcode_out = r_instr[INSTR_W-1 -: 4];
    assign pc_out     = r_pc_out;
    assign valid_out  = r_valid;

    // Control FSM, PC, fetch tracking, hold buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= '0;
            r_fetch_vld <= 1'b0;
            r_hold_buf  <= '0;
            r_hold_vld  <= 1'b0;
            r_instr     <= '0;
            r_pc_out    <= '0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_instr  <= '0;
                    r_pc_out <= '0;
                    r_valid  <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        // In-flight word is dropped; HALT is only left by reset.
                        r_state     <= ST_HALT;
                        r_fetch_vld <= 1'b0;
                        r_hold_vld  <= 1'b0;
                        r_instr     <= '0;
                        r_pc_out    <= '0;
                        r_valid     <= 1'b0;
                    end else if (jump_en) begin
                        // Redirect wins over stall; younger work is squashed.
                        r_pc        <= jump_addr;
                        r_fetch_vld <= 1'b0;
                        r_hold_vld  <= 1'b0;
                        r_instr     <= '0;
                        r_pc_out    <= '0;
                        r_valid     <= 1'b0;
                    end else if (stall) begin
                        // Park the returning word once; memory is not read
                        // again until the stall is released.
                        if (!r_hold_vld && r_fetch_vld) begin
                            r_hold_buf <= imem_data;
                            r_hold_vld <= 1'b1;
                        end
                    end else begin
                        r_instr     <= r_fetch_vld ? w_fetch_word : '0;
                        r_pc_out    <= r_fetch_vld ? r_fetch_pc : '0;
                        r_valid     <= r_fetch_vld;
                        r_fetch_pc  <= r_pc;
                        r_fetch_vld <= 1'b1;
                        r_pc        <= r_pc + c_pc_one;
                        r_hold_vld  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_HALT;
                    r_fetch_vld <= 1'b0;
                    r_hold_vld  <= 1'b0;
                    r_instr     <= '0;
                    r_pc_out    <= '0;
                    r_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
